addmod_rr_sched: RTL and testbench

Round-robin scheduler that shares one modular adder (addmodDP, computes (A+B) mod BLS381_CHAR on `WORD_SIZE*2-bit operands) among NREQ requesters.
- Two-stage pipeline with valid/ready handshakes on both the request and response sides, and full backpressure.
- Placed between the Fp-arithmetic issue logic and the single shared addmodDP instance. It replaces per-unit adder copies.

---
 rtl/addmod_rr_sched.sv | 109 ++++++++++
 tb/tb_addmod_rr_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addmod_rr_sched.sv
// addmod_rr_sched: round-robin scheduler sharing one modular adder among NREQ requesters
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b/req_tag   : packed operands and tag, requester i at [i*W +: W]
//   rsp_valid/rsp_ready   : result handshake toward the consumer
//   rsp_id/rsp_data/rsp_tag : owner index, (a+b) mod p, echoed tag
//   inflight              : ops held in the two pipeline stages (0..2)
`ifndef WORD_SIZE
`define WORD_SIZE 192
`endif
`ifndef BLS381_CHAR
`define BLS381_CHAR 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
`endif

`ifndef ADDMODDP_EXTERNAL
module addmodDP #(
  parameter int DW = `WORD_SIZE*2
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  localparam logic [DW:0] P = (DW+1)'(`BLS381_CHAR);
  logic [DW:0] s, d;
  assign s = {1'b0, a} + {1'b0, b};
  assign d = s - P;
  assign y = (s >= P) ? d[DW-1:0] : s[DW-1:0];
endmodule
`endif

module addmod_rr_sched #(
  parameter  int NREQ = 4,
  parameter  int DW   = `WORD_SIZE*2,
  parameter  int TAGW = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [1:0]           inflight
);
  logic [IW-1:0]   rr_ptr, gnt_id, s1_id;
  logic            gnt_found, s1_valid, adv1, adv2;
  logic [DW-1:0]   s1_a, s1_b, sum;
  logic [TAGW-1:0] s1_tag;
  // rsp_valid is the S2 valid flag itself
  assign adv2     = !rsp_valid || rsp_ready;
  assign adv1     = !s1_valid || adv2;
  assign inflight = {s1_valid & rsp_valid, s1_valid ^ rsp_valid};
  // First valid requester after rr_ptr, searching upward with wrap
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IW'(idx);
      end
    end
  end
  // Gated by rst_n so no requester sees an accept while the pipeline is held in reset
  assign req_ready = (rst_n && adv1 && gnt_found) ? (NREQ'(1) << gnt_id) : '0;
  addmodDP #(.DW(DW)) u_add (.a(s1_a), .b(s1_b), .y(sum));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= IW'(NREQ-1);
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tag    <= '0;
      s1_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_id    <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= gnt_found;
        if (gnt_found) begin
          s1_a   <= req_a[int'(gnt_id)*DW +: DW];
          s1_b   <= req_b[int'(gnt_id)*DW +: DW];
          s1_tag <= req_tag[int'(gnt_id)*TAGW +: TAGW];
          s1_id  <= gnt_id;
          rr_ptr <= gnt_id;
        end
      end
      if (adv2) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_data <= sum;
          rsp_tag  <= s1_tag;
          rsp_id   <= s1_id;
        end
      end
    end
  end
endmodule

// File: tb/tb_addmod_rr_sched.sv
// tb_addmod_rr_sched: table vectors plus scoreboard checks for addmod_rr_sched
`ifndef WORD_SIZE
`define WORD_SIZE 192
`endif
`ifndef BLS381_CHAR
`define BLS381_CHAR 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
`endif

module tb_addmod_rr_sched;
  localparam int NREQ = 4;
  localparam int DW   = `WORD_SIZE*2;
  localparam int TAGW = 4;
  localparam int IW   = $clog2(NREQ);
  localparam logic [DW-1:0] P = DW'(`BLS381_CHAR);

  logic                 clk = 0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*DW-1:0]   req_a, req_b;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 rsp_valid, rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [DW-1:0]        rsp_data;
  logic [TAGW-1:0]      rsp_tag;
  logic [1:0]           inflight;

  addmod_rr_sched #(.NREQ(NREQ), .DW(DW), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              id;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   exp;
  } vec_t;
  typedef struct {
    int              id;
    logic [DW-1:0]   data;
    logic [TAGW-1:0] tag;
  } exp_t;

  int   pass = 0, total = 0;
  exp_t sb[$];
  int   gnt_log[$];
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass++;
  endtask

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[DW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 30; c++) begin
      if (inflight == 0 && !rsp_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) begin
      total++;
      $display("FAIL wait_idle: inflight=%0d rsp_valid=%0b after 30 cycles, expected drain", inflight, rsp_valid);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rsp_valid"}, DW'(rsp_valid), 0);
    chk({nm, "_inflight"},  DW'(inflight), 0);
    chk({nm, "_req_ready"}, DW'(req_ready), 0);
    chk({nm, "_rsp_id"},    DW'(rsp_id), 0);
    chk({nm, "_rsp_data"},  rsp_data, 0);
    chk({nm, "_rsp_tag"},   DW'(rsp_tag), 0);
  endtask

  // Scoreboard: push model results on request handshakes, pop on response handshakes
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        sb.push_back('{i, mod_add(req_a[i*DW +: DW], req_b[i*DW +: DW]), req_tag[i*TAGW +: TAGW]});
        gnt_log.push_back(i);
      end
    if ($countones(req_ready) > 1) begin
      total++;
      $display("FAIL ready_onehot: req_ready=%b, expected at most one bit", req_ready);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: response id %0d data %0h, expected none", rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        chk("sb_id",   DW'(rsp_id), DW'(e.id));
        chk("sb_data", rsp_data, e.data);
        chk("sb_tag",  DW'(rsp_tag), DW'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tbl[0] = '{2, DW'(5), DW'(7), 4'd3, DW'(12)};
    tbl[1] = '{0, P - 1, DW'(2), 4'd5, DW'(1)};
    tbl[2] = '{0, P - 1, DW'(1), 4'd6, DW'(0)};
    tbl[3] = '{3, P - 2, P - 3, 4'd9, P - 5};
    tbl[4] = '{1, DW'(0), DW'(0), 4'd15, DW'(0)};
    rst_n = 0;
    rsp_ready = 1;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = DW'(100 + i);
      req_b[i*DW +: DW] = DW'(10 * i);
      req_tag[i*TAGW +: TAGW] = TAGW'(i + 8);
    end
    req_valid = '1;
    repeat (2) step();
    chk_reset_vals("reset");
    // Fairness: all requesters valid, grants rotate 0,1,2,3 with no bubble
    gnt_log.delete();
    rst_n = 1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k >= 2) chk("fair_nobubble", DW'(rsp_valid), 1);
    end
    req_valid = '0;
    chk("fair_count", DW'(gnt_log.size()), 12);
    for (int k = 0; k < gnt_log.size(); k++) chk("fair_order", DW'(gnt_log[k]), DW'(k % NREQ));
    wait_idle();
    // Single-op vectors, including wrap-around of the modulus
    foreach (tbl[t]) begin
      req_a[tbl[t].id*DW +: DW] = tbl[t].a;
      req_b[tbl[t].id*DW +: DW] = tbl[t].b;
      req_tag[tbl[t].id*TAGW +: TAGW] = tbl[t].tag;
      req_valid = NREQ'(1) << tbl[t].id;
      ok = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (req_ready[tbl[t].id]) begin
          ok = 1;
          break;
        end
      end
      chk("vec_accept", DW'(ok), 1);
      step();
      req_valid = '0;
      chk("vec_s1_inflight", DW'(inflight), 1);
      chk("vec_s1_rsp_valid", DW'(rsp_valid), 0);
      step();
      chk("vec_rsp_valid", DW'(rsp_valid), 1);
      chk("vec_rsp_id",    DW'(rsp_id), DW'(tbl[t].id));
      chk("vec_rsp_data",  rsp_data, tbl[t].exp);
      chk("vec_rsp_tag",   DW'(rsp_tag), DW'(tbl[t].tag));
      chk("vec_s2_inflight", DW'(inflight), 1);
      step();
      chk("vec_done_valid", DW'(rsp_valid), 0);
      chk("vec_done_inflight", DW'(inflight), 0);
    end
    wait_idle();
    // Skip idle: last grant was requester 1, only 1 and 3 valid
    gnt_log.delete();
    req_valid = 4'b1010;
    repeat (4) step();
    req_valid = '0;
    chk("skip_count", DW'(gnt_log.size()), 4);
    for (int k = 0; k < gnt_log.size(); k++) chk("skip_order", DW'(gnt_log[k]), (k % 2 == 0) ? DW'(3) : DW'(1));
    wait_idle();
    // Backpressure: stall the consumer with the pipeline full
    gnt_log.delete();
    req_valid = '1;
    repeat (3) step();
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_rsp_valid", DW'(rsp_valid), 1);
      chk("bp_hold_id",   DW'(rsp_id), 3);
      chk("bp_hold_data", rsp_data, mod_add(req_a[3*DW +: DW], req_b[3*DW +: DW]));
      chk("bp_hold_tag",  DW'(rsp_tag), DW'(req_tag[3*TAGW +: TAGW]));
      chk("bp_inflight",  DW'(inflight), 2);
      chk("bp_req_ready", DW'(req_ready), 0);
    end
    rsp_ready = 1;
    step();
    chk("bp_next_valid", DW'(rsp_valid), 1);
    chk("bp_next_id",    DW'(rsp_id), 0);
    step();
    req_valid = '0;
    for (int k = 0; k < gnt_log.size(); k++) chk("bp_order", DW'(gnt_log[k]), DW'((2 + k) % NREQ));
    wait_idle();
    // Reset with two ops in flight: discarded, requester 0 granted first afterwards
    req_valid = '1;
    rsp_ready = 0;
    repeat (2) step();
    chk("rst_full_inflight", DW'(inflight), 2);
    #2;
    rst_n = 0;
    #1;
    chk_reset_vals("rst_mid");
    sb.delete();
    gnt_log.delete();
    req_valid = 4'b0001;
    rsp_ready = 1;
    step();
    rst_n = 1;
    step();
    req_valid = '0;
    repeat (3) step();
    chk("rst_first_count", DW'(gnt_log.size()), 1);
    if (gnt_log.size() > 0) chk("rst_first_grant", DW'(gnt_log[0]), 0);
    wait_idle();
    chk("sb_empty", DW'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
